// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports and two write ports
// (port 1 wins on collision), optional bypass and zero register, and a bulk-clear sweep.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              w0_en,
   input  logic [ADDR_W-1:0] w0_add,
   input  logic [DATA_W-1:0] w0_data,
   input  logic              w1_en,
   input  logic [ADDR_W-1:0] w1_add,
   input  logic [DATA_W-1:0] w1_data,
   input  logic [ADDR_W-1:0] rl_add,
   input  logic [ADDR_W-1:0] rr_add,
   output logic [DATA_W-1:0] rl_data,
   output logic [DATA_W-1:0] rr_data,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_idx;
   logic              r_busy;
   logic              r_done;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic w_wr_ok;
   logic w_w1_commit;
   logic w_w0_commit;

   // A write commits only outside reset and outside the sweep; port 0 yields to port 1.
   assign w_wr_ok     = rst && (r_state != S_SWEEP);
   assign w_w1_commit = w_wr_ok && w1_en && !(ZERO_REG && (w1_add == '0));
   assign w_w0_commit = w_wr_ok && w0_en && !(ZERO_REG && (w0_add == '0))
                        && !(w1_en && (w1_add == w0_add));

   function automatic logic [DATA_W-1:0] f_read(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic              c1,
      input logic [ADDR_W-1:0] a1,
      input logic [DATA_W-1:0] d1,
      input logic              c0,
      input logic [ADDR_W-1:0] a0,
      input logic [DATA_W-1:0] d0
   );
      logic [DATA_W-1:0] v;
      v = stored;
      if (BYPASS && c0 && (addr == a0)) v = d0;
      if (BYPASS && c1 && (addr == a1)) v = d1;
      if (ZERO_REG && (addr == '0))     v = '0;
      return v;
   endfunction

   assign rl_data = f_read(rl_add, r_mem[rl_add], w_w1_commit, w1_add, w1_data,
                           w_w0_commit, w0_add, w0_data);
   assign rr_data = f_read(rr_add, r_mem[rr_add], w_w1_commit, w1_add, w1_data,
                           w_w0_commit, w0_add, w0_data);

   assign clr_busy = r_busy;
   assign clr_done = r_done;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (clr_req) begin
                  r_state <= S_SWEEP;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_SWEEP: begin
               r_mem[r_idx] <= '0;
               if (r_idx == ADDR_W'(DEPTH-1)) begin
                  r_state <= S_DONE;
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_idx <= r_idx + ADDR_W'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
         if (w_w0_commit) r_mem[w0_add] <= w0_data;
         if (w_w1_commit) r_mem[w1_add] <= w1_data;
      end
   end
endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param: two instances (bypass+zero-reg and plain)
// checked every cycle against a behavioural model, plus directed scenarios.
module tb_regfile_param;
   logic        clk = 1'b0;
   logic        rst, w0_en, w1_en, clr_req;
   logic [4:0]  w0_add, w1_add, rl_add, rr_add;
   logic [31:0] w0_data, w1_data;
   logic [31:0] rl_a, rr_a, rl_b, rr_b;
   logic        busy_a, done_a, busy_b, done_b;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] m_mem [2][32];
   int          m_swp [2];
   bit          m_done[2];
   bit          p_zero[2] = '{1'b1, 1'b0};
   bit          p_byp [2] = '{1'b1, 1'b0};

   always #5 clk = ~clk;

   regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
      .clk(clk), .rst(rst),
      .w0_en(w0_en), .w0_add(w0_add), .w0_data(w0_data),
      .w1_en(w1_en), .w1_add(w1_add), .w1_data(w1_data),
      .rl_add(rl_add), .rr_add(rr_add), .rl_data(rl_a), .rr_data(rr_a),
      .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a));

   regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
      .clk(clk), .rst(rst),
      .w0_en(w0_en), .w0_add(w0_add), .w0_data(w0_data),
      .w1_en(w1_en), .w1_add(w1_add), .w1_data(w1_data),
      .rl_add(rl_add), .rr_add(rr_add), .rl_data(rl_b), .rr_data(rr_b),
      .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit f_c1(int i);
      return rst && (m_swp[i] < 0) && w1_en && !(p_zero[i] && (w1_add == 5'd0));
   endfunction

   function automatic bit f_c0(int i);
      return rst && (m_swp[i] < 0) && w0_en && !(p_zero[i] && (w0_add == 5'd0))
             && !(w1_en && (w1_add == w0_add));
   endfunction

   function automatic logic [31:0] exp_rd(int i, logic [4:0] a);
      if (p_zero[i] && (a == 5'd0))             return 32'd0;
      if (p_byp[i] && f_c1(i) && (a == w1_add)) return w1_data;
      if (p_byp[i] && f_c0(i) && (a == w0_add)) return w0_data;
      return m_mem[i][a];
   endfunction

   task automatic check_all();
      chk("rl_a",   rl_a,          exp_rd(0, rl_add));
      chk("rr_a",   rr_a,          exp_rd(0, rr_add));
      chk("busy_a", 32'(busy_a),   32'(m_swp[0] >= 0));
      chk("done_a", 32'(done_a),   32'(m_done[0]));
      chk("rl_b",   rl_b,          exp_rd(1, rl_add));
      chk("rr_b",   rr_b,          exp_rd(1, rr_add));
      chk("busy_b", 32'(busy_b),   32'(m_swp[1] >= 0));
      chk("done_b", 32'(done_b),   32'(m_done[1]));
   endtask

   task automatic model_edge();
      bit c1, c0;
      for (int i = 0; i < 2; i++) begin
         c1 = f_c1(i);
         c0 = f_c0(i);
         if (!rst) begin
            for (int k = 0; k < 32; k++) m_mem[i][k] = 32'd0;
            m_swp[i]  = -1;
            m_done[i] = 1'b0;
         end else if (m_swp[i] >= 0) begin
            m_mem[i][m_swp[i]] = 32'd0;
            if (m_swp[i] == 31) begin
               m_swp[i]  = -1;
               m_done[i] = 1'b1;
            end else begin
               m_swp[i]++;
            end
         end else begin
            if (c0) m_mem[i][w0_add] = w0_data;
            if (c1) m_mem[i][w1_add] = w1_data;
            if (m_done[i])    m_done[i] = 1'b0;
            else if (clr_req) m_swp[i]  = 0;
         end
      end
   endtask

   task automatic step();
      #2;
      check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rand_cycles(int n, int clr_pct, int rst_pct);
      for (int c = 0; c < n; c++) begin
         rst     = ($urandom_range(0, 99) >= rst_pct);
         clr_req = ($urandom_range(0, 99) < clr_pct);
         w0_en   = 1'($urandom);
         w1_en   = 1'($urandom);
         w0_add  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         w1_add  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         rl_add  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         rr_add  = ($urandom_range(0, 3) == 0) ? rl_add : 5'($urandom);
         w0_data = $urandom;
         w1_data = $urandom;
         step();
      end
      rst = 1'b1; clr_req = 1'b0; w0_en = 1'b0; w1_en = 1'b0;
   endtask

   task automatic fill_all();
      for (int a = 0; a < 32; a++) begin
         w0_en = 1'b1; w0_add = 5'(a); w0_data = $urandom | 32'd1; rl_add = 5'(a);
         step();
      end
      w0_en = 1'b0;
   endtask

   task automatic read_zero(string tag);
      for (int a = 0; a < 32; a++) begin
         rl_add = 5'(a); rr_add = 5'(31 - a);
         #1;
         chk(tag, rl_a, 32'd0);
         chk(tag, rr_b, 32'd0);
      end
   endtask

   task automatic sweep_len(string tag, bit wr_during);
      int n;
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      if (wr_during) begin
         w0_en = 1'b1; w0_add = 5'd31; w0_data = 32'h7777_7777;
      end
      n = 0;
      while (busy_a && n < 40) begin
         step();
         n++;
      end
      chk(tag, 32'(n), 32'd32);
      chk({tag, "_done"}, 32'(done_a), 32'd1);
      w0_en = 1'b0;
      step();
      chk({tag, "_idle"}, 32'(done_a), 32'd0);
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 2; i++) begin m_swp[i] = -1; m_done[i] = 1'b0; end
      rst = 1'b0; clr_req = 1'b0; w1_en = 1'b0; w1_add = 5'd0; w1_data = 32'd0;
      w0_en = 1'b1; w0_add = 5'd3; w0_data = 32'hDEAD_BEEF; rl_add = 5'd3; rr_add = 5'd3;
      repeat (2) begin
         @(posedge clk);
         model_edge();
      end
      #1;
      rst = 1'b1; w0_en = 1'b0;
      #1;
      chk("rst_rl3", rl_a, 32'd0);
      chk("rst_rr3", rr_b, 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      step();

      rand_cycles(300, 0, 0);

      w0_en = 1'b1; w0_add = 5'd7; w0_data = 32'h1111_1111;
      w1_en = 1'b1; w1_add = 5'd7; w1_data = 32'h2222_2222; rl_add = 5'd7;
      step();
      w0_en = 1'b0; w1_en = 1'b0;
      #1;
      chk("coll_a", rl_a, 32'h2222_2222);
      chk("coll_b", rl_b, 32'h2222_2222);
      w0_en = 1'b1; w0_add = 5'd5; w0_data = 32'hA5A5_A5A5;
      w1_en = 1'b1; w1_add = 5'd6; w1_data = 32'h5A5A_5A5A;
      step();
      w0_en = 1'b0; w1_en = 1'b0; rl_add = 5'd5; rr_add = 5'd6;
      #1;
      chk("dual_w0", rl_a, 32'hA5A5_A5A5);
      chk("dual_w1", rr_b, 32'h5A5A_5A5A);

      w1_en = 1'b1; w1_add = 5'd9; w1_data = 32'h1234_5678;
      step();
      w1_data = 32'hCAFE_F00D; rr_add = 5'd9;
      #1;
      chk("byp_on",  rr_a, 32'hCAFE_F00D);
      chk("byp_off", rr_b, 32'h1234_5678);
      step();
      w1_en = 1'b0;
      #1;
      chk("byp_off_next", rr_b, 32'hCAFE_F00D);

      w0_en = 1'b1; w0_add = 5'd0; w0_data = 32'hFFFF_FFFF; rl_add = 5'd0;
      #1;
      chk("zero_same", rl_a, 32'd0);
      step();
      w0_en = 1'b0;
      #1;
      chk("zero_next", rl_a, 32'd0);
      chk("nozero_next", rl_b, 32'hFFFF_FFFF);
      step();

      fill_all();
      sweep_len("sweep", 1'b1);
      read_zero("clr_rd");
      step();

      fill_all();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (10) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      #1;
      chk("abort_busy_a", 32'(busy_a), 32'd0);
      chk("abort_busy_b", 32'(busy_b), 32'd0);
      seen = 0;
      repeat (40) begin
         step();
         if (done_a || done_b) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      read_zero("abort_rd");
      fill_all();
      sweep_len("resweep", 1'b0);

      rand_cycles(600, 2, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file for the core's decode/writeback stages: the next generation of the 32x32 two-read, one-write register file. It adds configurable width and depth, a second write port with fixed priority, optional write-to-read bypass, an optional hardwired zero register, and a sequenced bulk-clear engine with a busy/done handshake. It sits between decode (read ports) and writeback (write ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary storage
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads return stored contents only
- Reset: synchronous, active-low; all state is sampled on the rising edge of `clk`.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-low reset
- w0_en  in  1  write enable, port 0
- w0_add  in  ADDR_W  write address, port 0
- w0_data  in  DATA_W  write data, port 0
- w1_en  in  1  write enable, port 1; has priority over port 0
- w1_add  in  ADDR_W  write address, port 1
- w1_data  in  DATA_W  write data, port 1
- rl_add  in  ADDR_W  left read address
- rr_add  in  ADDR_W  right read address
- rl_data  out  DATA_W  left read data; combinational
- rr_data  out  DATA_W  right read data; combinational
- clr_req  in  1  bulk-clear request; sampled in IDLE only
- clr_busy  out  1  high while a clear sweep is in progress
- clr_done  out  1  one-cycle pulse when a sweep completes

## Operation
- **Storage:** DEPTH x DATA_W flops.
- **Reset (rst=0 at an edge):**
  - every register is set to 0
  - FSM goes to IDLE and the sweep index to 0
  - clr_busy=0, clr_done=0
  - rl_data and rr_data read 0 from the next cycle on
- **Writes (IDLE or DONE state):**
  - w1_en=1: mem[w1_add] <= w1_data
  - w0_en=1: mem[w0_add] <= w0_data, unless w1_en=1 and w1_add==w0_add, in which case port 1 wins and port 0 is dropped
  - ZERO_REG=1: writes to address 0 are dropped on both ports
- **Reads:**
  - rX_data = mem[rX_add], combinational
  - With BYPASS=1, the read returns write data when a port writes the read address this cycle:
    - rX_add==w1_add with w1_en=1: return w1_data
    - otherwise rX_add==w0_add with w0_en=1: return w0_data
  - Bypass applies only when the write would actually commit. It never applies to address 0 when ZERO_REG=1, and never in SWEEP.
  - ZERO_REG=1 and rX_add==0: rX_data=0
- **Clear FSM states:**
  - IDLE:
    - clr_req=1 -> SWEEP, idx=0
  - SWEEP:
    - each cycle mem[idx] <= 0 and idx <= idx+1
    - when idx==DEPTH-1 -> DONE
    - w0_en and w1_en are ignored, with no commit and no bypass
    - clr_req is ignored
    - reads return the current array contents, so cleared entries read 0
  - DONE:
    - clr_done=1 for this one cycle
    - writes accepted normally
    - next state is IDLE unconditionally
    - clr_req in DONE is ignored; it must be held to be seen again in IDLE
- **Outputs:** clr_busy = (state==SWEEP); clr_done = (state==DONE).
- **Index width:** idx is ADDR_W bits; its terminal compare uses DEPTH-1, with no wrap past the last entry.

## Timing
- **Write-to-read latency:**
  - committed write at edge k is visible on the read ports in cycle k+1
  - with BYPASS=1 it is also visible in cycle k, before the edge
- **Clear request:** clr_req=1 in IDLE, sampled at edge k:
  - clr_busy=1 from edge k through edge k+DEPTH
  - register i is zeroed at edge k+1+i
  - clr_done=1 for the cycle following edge k+DEPTH
  - IDLE at edge k+DEPTH+1
- **Sweep length:** DEPTH busy cycles plus 1 done cycle.
- **Reset mid-sweep:** rst=0 at any edge aborts the sweep at that edge, zeroes all registers, goes to IDLE, and no clr_done pulse is produced.
- **Simultaneous reset and write:** reset wins and the write is dropped.
- **Read ports:** both read ports may use the same address, and each returns the identical value.

## Test plan
- **Reset:** rst=0 for 2 cycles with w0_en=1, w0_add=3, w0_data=0xDEADBEEF; release, then read rl_add=3 -> 0; clr_busy=0, clr_done=0.
- **Write port collision:** w0 and w1 both write address 7 with 0x11111111 and 0x22222222 -> next cycle rl_data=0x22222222. Also w0->5=0xA5A5A5A5 and w1->6=0x5A5A5A5A in the same cycle -> both stored.
- **Bypass:** BYPASS=1 with w1_en=1, w1_add=9, w1_data=0xCAFEF00D and rr_add=9 -> rr_data=0xCAFEF00D in the same cycle. BYPASS=0 with the same stimulus -> old value in that cycle, 0xCAFEF00D next cycle.
- **Zero register:** ZERO_REG=1, write address 0 with 0xFFFFFFFF and read address 0 in the same and next cycle -> 0 both times. ZERO_REG=0 -> 0xFFFFFFFF next cycle.
- **Clear sweep:** DEPTH=32, fill all registers with nonzero values, pulse clr_req, then drive w0 writes to address 31 during the sweep:
  - clr_busy is high for exactly 32 cycles, then clr_done is high for 1 cycle
  - every register reads 0 afterwards
  - the writes issued during the sweep are dropped
- **Reset mid-sweep:** assert rst=0 at sweep cycle 10 -> clr_busy=0 next cycle, no clr_done, all registers 0. A subsequent clr_req then runs a full 32-cycle sweep.
